// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and burst-counter sizing for the 8-way
// round-robin mux arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

   // Enough bits to hold 0..max_burst inclusive.
   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Circular first-set-bit finder: scans vec from index start upward,
// wrapping modulo 8.
module rr_pick8
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] vec,
   input  logic [SEL_W-1:0] start,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   // Rotate so start lands at bit 0, encode the lowest set bit, then undo the rotation.
   always_comb begin
      rot   = N_REQ'({vec, vec} >> start);
      found = 1'b0;
      off   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            off   = SEL_W'(i);
         end
      end
      idx = start + off;
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter with burst limit driving the registered select of a
// shared 8:1 mux; all outputs are registered.
module mux8_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             gnt_valid
);

   localparam int CNT_W = cnt_width(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   arb_state_t       state, state_n;
   logic [SEL_W-1:0] owner, owner_n;
   logic [SEL_W-1:0] ptr, ptr_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   logic [N_REQ-1:0] gnt_n;
   logic [SEL_W-1:0] sel_n;
   logic             gnt_valid_n;

   logic [N_REQ-1:0] others;
   logic [N_REQ-1:0] pick_vec;
   logic [SEL_W-1:0] pick_start;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;
   logic             release_now;

   assign others      = req & ~(N_REQ'(1) << owner);
   assign release_now = !req[owner] || ((cnt == CNT_MAX) && (others != '0));

   // One picker serves both states: fresh search from ptr, or hand-off from owner+1.
   assign pick_vec   = (state == IDLE) ? req : others;
   assign pick_start = (state == IDLE) ? ptr : owner + SEL_W'(1);

   rr_pick8 u_pick (
      .vec   (pick_vec),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         ptr       <= '0;
         cnt       <= '0;
         gnt       <= '0;
         sel       <= '0;
         gnt_valid <= 1'b0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         ptr       <= ptr_n;
         cnt       <= cnt_n;
         gnt       <= gnt_n;
         sel       <= sel_n;
         gnt_valid <= gnt_valid_n;
      end
   end

   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               state_n = GRANT;
               owner_n = pick_idx;
               cnt_n   = CNT_W'(1);
            end
         end
         GRANT: begin
            if (!release_now) begin
               if (cnt != CNT_MAX) cnt_n = cnt + CNT_W'(1);
            end else begin
               ptr_n = owner + SEL_W'(1);
               if (pick_found) begin
                  owner_n = pick_idx;
                  cnt_n   = CNT_W'(1);
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are computed from next state so they can be registered without a cycle of lag.
   always_comb begin
      gnt_n       = '0;
      sel_n       = sel;
      gnt_valid_n = 1'b0;
      if (state_n == GRANT) begin
         gnt_n       = N_REQ'(1) << owner_n;
         sel_n       = owner_n;
         gnt_valid_n = 1'b1;
      end
   end

endmodule
